// File: rtl/fifo_line_reader_pkg.sv
// Shared definitions for the line reader: FSM state encoding, default
// geometry, and a counter-width helper.
package fifo_line_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    DRAIN
  } state_t;

  localparam int unsigned DEF_DW     = 24;
  localparam int unsigned DEF_LINE_W = 1920;
  localparam int unsigned DEF_LINES  = 1080;

  // A count of one still needs a one-bit register, so the width never drops to zero.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_line_reader.sv
// Streams whole lines from a show-ahead FIFO into a valid/ready pixel
// stream. Each pixel is tagged with start-of-line, end-of-line and end-of-frame.
module fifo_line_reader
  import fifo_line_reader_pkg::*;
#(
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned LINE_W = DEF_LINE_W,
  parameter int unsigned LINES  = DEF_LINES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          fifo_re,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_valid,
  input  logic          fifo_afull,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sol,
  output logic          out_eol,
  output logic          out_eof,
  output logic          busy,
  output logic          underrun
);

  localparam int unsigned CW = cnt_width(LINE_W);
  localparam int unsigned LW = cnt_width(LINES);
  localparam logic [CW-1:0] COL_LAST  = CW'(LINE_W - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic          xfer;
  logic          col_last;
  logic          line_last;
  logic          drain_done;

  always_comb begin
    xfer       = (state == STREAM) && fifo_valid && (!out_valid || out_ready);
    col_last   = (col == COL_LAST);
    line_last  = (line == LINE_LAST);
    drain_done = !out_valid || out_ready;
    fifo_re    = xfer;
    busy       = (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = PRIME;
      PRIME:  if (fifo_afull) state_nxt = STREAM;
      STREAM: if (xfer && col_last) state_nxt = line_last ? DRAIN : PRIME;
      DRAIN:  if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      line <= '0;
    end else begin
      if (xfer) col <= col_last ? '0 : col + CW'(1);
      if (state == DRAIN && drain_done)       line <= '0;
      else if (xfer && col_last && !line_last) line <= line + LW'(1);
    end
  end

  // Markers travel with the data word, so a stalled beat keeps its tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (xfer) begin
      out_data  <= fifo_dout;
      out_valid <= 1'b1;
      out_sol   <= (col == '0);
      out_eol   <= col_last;
      out_eof   <= col_last && line_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underrun <= 1'b0;
    else if (state == STREAM && col != '0 && !fifo_valid) underrun <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_line_reader.sv
// Directed bench for fifo_line_reader (LINE_W=4, LINES=2): a behavioural FIFO
// feeds the DUT and a scoreboard holds the expected beats in order.
module tb_fifo_line_reader;

  localparam int unsigned DW = 24;
  localparam int unsigned LW = 4;
  localparam int unsigned LN = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          fifo_re;
  logic [DW-1:0] fifo_dout;
  logic          fifo_valid;
  logic          fifo_afull;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sol;
  logic          out_eol;
  logic          out_eof;
  logic          busy;
  logic          underrun;

  always #5 clk = ~clk;

  fifo_line_reader #(.DW(DW), .LINE_W(LW), .LINES(LN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fifo_re(fifo_re),
    .fifo_dout(fifo_dout), .fifo_valid(fifo_valid), .fifo_afull(fifo_afull),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .underrun(underrun)
  );

  // Show-ahead FIFO model; hold_en masks fifo_valid once rd_ptr reaches hold_at.
  logic [DW-1:0] mem [0:63];
  int unsigned   wr_ptr  = 0;
  int unsigned   rd_ptr  = 0;
  int unsigned   hold_at = 0;
  logic          hold_en = 1'b0;
  logic          flush   = 1'b0;

  assign fifo_dout  = mem[rd_ptr[5:0]];
  assign fifo_valid = (wr_ptr != rd_ptr) && !(hold_en && rd_ptr == hold_at);
  assign fifo_afull = (wr_ptr - rd_ptr) >= LW;

  always @(posedge clk) begin
    if (flush)        rd_ptr <= wr_ptr;
    else if (fifo_re) rd_ptr <= rd_ptr + 1;
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sol;
    logic          eol;
    logic          eof;
  } beat_t;

  beat_t       sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned nacc = 0;
  logic        eof_acc = 1'b0;
  logic        start_on_eof = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d, input int unsigned idx);
    beat_t b;
    mem[wr_ptr[5:0]] = d;
    wr_ptr++;
    b.data = d;
    b.sol  = (idx % LW) == 0;
    b.eol  = (idx % LW) == LW - 1;
    b.eof  = (idx == LW * LN - 1);
    sb.push_back(b);
  endtask

  task automatic push_frame(input logic [DW-1:0] base);
    for (int unsigned i = 0; i < LW * LN; i++) push_word(base + DW'(i), i);
  endtask

  // Called at the falling edge with inputs already set for the coming rising edge.
  task automatic tick();
    bit fire;
    fire = 1'b0;
    if (eof_acc) begin
      chk("busy_after_eof", 32'(busy), 32'd0);
      eof_acc = 1'b0;
    end
    if (out_valid) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        chk("data", 32'(out_data), 32'(sb[0].data));
        chk("sol",  32'(out_sol),  32'(sb[0].sol));
        chk("eol",  32'(out_eol),  32'(sb[0].eol));
        chk("eof",  32'(out_eof),  32'(sb[0].eof));
        if (out_ready) begin
          if (sb[0].eof) begin
            eof_acc = 1'b1;
            if (start_on_eof) begin
              start = 1'b1;
              fire  = 1'b1;
            end
          end
          void'(sb.pop_front());
          nacc++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (fire) begin
      start        = 1'b0;
      start_on_eof = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input int unsigned max);
    int unsigned n;
    n = 0;
    while ((sb.size() != 0 || busy || eof_acc) && n < max) begin
      tick();
      n++;
    end
    chk("frame_done", 32'(sb.size() == 0 && !busy), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},    32'(out_valid), 32'd0);
    chk({tag, "_data"},     32'(out_data),  32'd0);
    chk({tag, "_sol"},      32'(out_sol),   32'd0);
    chk({tag, "_eol"},      32'(out_eol),   32'd0);
    chk({tag, "_eof"},      32'(out_eof),   32'd0);
    chk({tag, "_underrun"}, 32'(underrun),  32'd0);
    chk({tag, "_busy"},     32'(busy),      32'd0);
    chk({tag, "_re"},       32'(fifo_re),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0;
    int unsigned base;
    int unsigned g;

    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Full frame, preloaded FIFO, downstream always ready.
    push_frame(24'h000001);
    n0 = nacc;
    pulse_start();
    chk("busy_start", 32'(busy), 32'd1);
    run_frame(60);
    chk("t1_count", nacc - n0, 32'd8);
    chk("t1_underrun", 32'(underrun), 32'd0);

    // Three words only: held in PRIME until the fourth arrives.
    for (int unsigned i = 0; i < 3; i++) push_word(24'h000010 + DW'(i), i);
    pulse_start();
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      chk("t2_re_prime", 32'(fifo_re), 32'd0);
      chk("t2_busy", 32'(busy), 32'd1);
    end
    push_word(24'h000013, 3);
    chk("t2_re_afull_cycle", 32'(fifo_re), 32'd0);
    tick();
    chk("t2_re_stream", 32'(fifo_re), 32'd1);
    for (int unsigned i = 4; i < 8; i++) push_word(24'h000010 + DW'(i), i);
    run_frame(60);

    // Downstream back-pressure toggling every cycle.
    push_frame(24'h000020);
    n0 = nacc;
    pulse_start();
    for (int unsigned k = 0; k < 40 && (sb.size() != 0 || busy); k++) begin
      out_ready = (k % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    run_frame(20);
    chk("t3_count", nacc - n0, 32'd8);

    // FIFO starves after column 1.
    base = wr_ptr;
    push_frame(24'h000030);
    hold_at = base + 2;
    hold_en = 1'b1;
    chk("t4_underrun_before", 32'(underrun), 32'd0);
    pulse_start();
    repeat (8) tick();
    chk("t4_underrun_set", 32'(underrun), 32'd1);
    chk("t4_re_starved", 32'(fifo_re), 32'd0);
    chk("t4_busy_wait", 32'(busy), 32'd1);
    hold_en = 1'b0;
    run_frame(40);
    chk("t4_underrun_sticky", 32'(underrun), 32'd1);

    // Reset mid-frame after the third word.
    push_frame(24'h000040);
    n0 = nacc;
    pulse_start();
    g = 0;
    while (nacc - n0 < 3 && g < 30) begin
      tick();
      g++;
    end
    chk("t5_three_words", nacc - n0, 32'd3);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async");
    flush = 1'b1;
    sb.delete();
    eof_acc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
    push_frame(24'h000050);
    repeat (3) tick();
    chk("t5_no_autostart_busy", 32'(busy), 32'd0);
    chk("t5_no_autostart_re", 32'(fifo_re), 32'd0);
    pulse_start();
    run_frame(60);

    // Starts while busy and on the final accept are both ignored.
    push_frame(24'h000060);
    pulse_start();
    for (int unsigned k = 0; k < 4; k++) begin
      if (busy) pulse_start();
      tick();
    end
    start_on_eof = 1'b1;
    run_frame(40);
    for (int unsigned i = 0; i < 8; i++) begin
      mem[wr_ptr[5:0]] = 24'h0000AA;
      wr_ptr++;
    end
    for (int unsigned k = 0; k < 6; k++) begin
      tick();
      chk("t6_idle_busy", 32'(busy), 32'd0);
      chk("t6_idle_re", 32'(fifo_re), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
